// File: rtl/cpu_io_pkg.sv
// Shared definitions for the basic computer's terminal I/O path.
// Holds the character width default, the output engine states and a counter-width helper.
package cpu_io_pkg;

  localparam int DWIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_BUSY,
    OUT_SEND
  } out_state_e;

  // A one-cycle print time still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Small synchronous FIFO that buffers host keystrokes ahead of INPR.
// Pushes into a full queue and pops from an empty queue are ignored.
module io_byte_fifo
  import cpu_io_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_terminal.sv
// Device side of the basic computer's I/O: feeds INPR/FGI from a keystroke queue
// and drains OUTR/FGO through a paced printer model with host handshake.
module io_terminal
  import cpu_io_pkg::*;
#(
  parameter int DWIDTH       = DWIDTH_DEFAULT,
  parameter int IN_DEPTH     = 4,
  parameter int PRINT_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DWIDTH-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DWIDTH-1:0] inpr,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [DWIDTH-1:0] outr,
  input  logic              out_strobe,
  output logic              fgo,
  output logic [DWIDTH-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              out_overrun
);

  localparam int CW  = $clog2(IN_DEPTH) + 1;
  localparam int CNW = cnt_width(PRINT_CYCLES);

  logic [DWIDTH-1:0] fifo_head;
  logic              fifo_full, fifo_empty, load;
  logic [CW-1:0]     fifo_count_unused;

  logic [DWIDTH-1:0] inpr_q, inpr_d;
  logic              fgi_q, fgi_d;

  out_state_e        state_q, state_d;
  logic [CNW-1:0]    cnt_q, cnt_d;
  logic              fgo_q, fgo_d;
  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              overrun_q, overrun_d;

  io_byte_fifo #(.DWIDTH(DWIDTH), .DEPTH(IN_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (host_in_valid),
    .push_data (host_in_data),
    .pop       (load),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  assign host_in_ready = !fifo_full;
  assign load          = !fgi_q && !fifo_empty;

  // INPR only reloads once the CPU has consumed the previous character.
  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    if (inp_ack && fgi_q) fgi_d = 1'b0;
    if (load) begin
      inpr_d = fifo_head;
      fgi_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inpr_q    <= '0;
      fgi_q     <= 1'b0;
      state_q   <= OUT_IDLE;
      cnt_q     <= '0;
      fgo_q     <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      inpr_q    <= inpr_d;
      fgi_q     <= fgi_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fgo_q     <= fgo_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OUT_IDLE: if (out_strobe) begin
        state_d = OUT_BUSY;
        cnt_d   = CNW'(PRINT_CYCLES - 1);
      end
      OUT_BUSY: begin
        if (cnt_q == '0) state_d = OUT_SEND;
        else             cnt_d   = cnt_q - CNW'(1);
      end
      OUT_SEND: if (host_out_ready) state_d = OUT_IDLE;
      default:  state_d = OUT_IDLE;
    endcase
  end

  // A strobe while the printer is occupied is dropped and only flagged.
  always_comb begin
    fgo_d     = fgo_q;
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    unique case (state_q)
      OUT_IDLE: if (out_strobe) begin
        data_d = outr;
        fgo_d  = 1'b0;
      end
      OUT_BUSY: begin
        if (out_strobe)    overrun_d = 1'b1;
        if (cnt_q == '0)   valid_d   = 1'b1;
      end
      OUT_SEND: begin
        if (out_strobe) overrun_d = 1'b1;
        if (host_out_ready) begin
          valid_d = 1'b0;
          fgo_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign inpr           = inpr_q;
  assign fgi            = fgi_q;
  assign fgo            = fgo_q;
  assign host_out_valid = valid_q;
  assign host_out_data  = data_q;
  assign out_overrun    = overrun_q;

endmodule

// File: tb/tb_io_terminal.sv
// Directed bench for io_terminal: reset, input queue, paced output, overrun,
// mid-operation reset and simultaneous input/output events.
module tb_io_terminal;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] host_in_data;
  logic       host_in_valid;
  logic       host_in_ready;
  logic [7:0] inpr;
  logic       fgi;
  logic       inp_ack;
  logic [7:0] outr;
  logic       out_strobe;
  logic       fgo;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready;
  logic       out_overrun;

  int passCount  = 0;
  int checkCount = 0;

  always #5 CLK = ~CLK;

  io_terminal #(.DWIDTH(8), .IN_DEPTH(4), .PRINT_CYCLES(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .inpr           (inpr),
    .fgi            (fgi),
    .inp_ack        (inp_ack),
    .outr           (outr),
    .out_strobe     (out_strobe),
    .fgo            (fgo),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .out_overrun    (out_overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_fgi"},     32'(fgi), 32'h0);
    checkOutput({tag, "_fgo"},     32'(fgo), 32'h1);
    checkOutput({tag, "_inpr"},    32'(inpr), 32'h0);
    checkOutput({tag, "_ready"},   32'(host_in_ready), 32'h1);
    checkOutput({tag, "_valid"},   32'(host_out_valid), 32'h0);
    checkOutput({tag, "_odata"},   32'(host_out_data), 32'h0);
    checkOutput({tag, "_overrun"}, 32'(out_overrun), 32'h0);
  endtask

  initial begin
    int lowCycles;
    int validCycles;
    logic [7:0] seenData;
    logic [7:0] expSeq [5];
    expSeq[0] = 8'h41; expSeq[1] = 8'h42; expSeq[2] = 8'h43;
    expSeq[3] = 8'h44; expSeq[4] = 8'h45;

    RST = 1'b1; host_in_data = '0; host_in_valid = 1'b0; inp_ack = 1'b0;
    outr = '0; out_strobe = 1'b0; host_out_ready = 1'b0;

    // Reset
    applyStimulus(2);
    checkResetValues("reset");
    RST = 1'b0;
    applyStimulus(1);

    // Input burst: 0x41 goes to INPR, 0x42..0x45 fill the queue, 0x46 refused
    host_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_in_data = 8'h41 + 8'(i);
      applyStimulus(1);
    end
    checkOutput("burst_fgi",   32'(fgi), 32'h1);
    checkOutput("burst_inpr",  32'(inpr), 32'h41);
    checkOutput("burst_full",  32'(host_in_ready), 32'h0);
    host_in_data = 8'h46;
    applyStimulus(1);
    host_in_valid = 1'b0;
    checkOutput("burst_still_full", 32'(host_in_ready), 32'h0);

    for (int i = 0; i < 5; i++) begin
      inp_ack = 1'b1;
      applyStimulus(1);
      inp_ack = 1'b0;
      checkOutput($sformatf("ack%0d_fgi_clr", i), 32'(fgi), 32'h0);
      applyStimulus(1);
      if (i < 4) begin
        checkOutput($sformatf("ack%0d_fgi_set", i), 32'(fgi), 32'h1);
        checkOutput($sformatf("ack%0d_inpr", i), 32'(inpr), 32'(expSeq[i + 1]));
      end
    end
    applyStimulus(2);
    checkOutput("drain_fgi",  32'(fgi), 32'h0);
    checkOutput("drain_inpr", 32'(inpr), 32'h45);
    checkOutput("drain_ready", 32'(host_in_ready), 32'h1);

    // Paced output with host always ready
    host_out_ready = 1'b1;
    outr = 8'h5A; out_strobe = 1'b1;
    applyStimulus(1);
    out_strobe = 1'b0; outr = 8'h00;
    lowCycles = (fgo == 1'b0) ? 1 : 0;
    validCycles = 0;
    seenData = '0;
    for (int i = 0; i < 20; i++) begin
      if (host_out_valid) begin
        validCycles++;
        seenData = host_out_data;
      end
      applyStimulus(1);
      if (fgo) break;
      lowCycles++;
    end
    checkOutput("print_fgo_low",   32'(lowCycles), 32'd5);
    checkOutput("print_valid_len", 32'(validCycles), 32'd1);
    checkOutput("print_data",      32'(seenData), 32'h5A);
    checkOutput("print_valid_end", 32'(host_out_valid), 32'h0);

    // Backpressure and overrun
    host_out_ready = 1'b0;
    outr = 8'h31; out_strobe = 1'b1;
    applyStimulus(1);
    outr = 8'h32;
    applyStimulus(1);
    out_strobe = 1'b0;
    checkOutput("ovr_flag",  32'(out_overrun), 32'h1);
    applyStimulus(4);
    checkOutput("bp_valid", 32'(host_out_valid), 32'h1);
    checkOutput("bp_data",  32'(host_out_data), 32'h31);
    checkOutput("bp_fgo",   32'(fgo), 32'h0);
    applyStimulus(3);
    checkOutput("bp_hold_valid", 32'(host_out_valid), 32'h1);
    checkOutput("bp_hold_data",  32'(host_out_data), 32'h31);
    checkOutput("bp_hold_fgo",   32'(fgo), 32'h0);
    host_out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp_accept_valid", 32'(host_out_valid), 32'h0);
    checkOutput("bp_accept_fgo",   32'(fgo), 32'h1);
    checkOutput("ovr_sticky",      32'(out_overrun), 32'h1);
    applyStimulus(6);
    checkOutput("ovr_no_second", 32'(host_out_valid), 32'h0);

    // Reset while printing with two characters queued
    host_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_in_data = 8'h61 + 8'(i);
      applyStimulus(1);
    end
    host_in_valid = 1'b0;
    outr = 8'h77; out_strobe = 1'b1;
    applyStimulus(1);
    out_strobe = 1'b0;
    checkOutput("pre_rst_fgi",  32'(fgi), 32'h1);
    checkOutput("pre_rst_inpr", 32'(inpr), 32'h61);
    RST = 1'b1;
    applyStimulus(1);
    checkResetValues("midrst");
    RST = 1'b0;
    validCycles = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      if (host_out_valid || fgi) validCycles++;
    end
    checkOutput("midrst_no_stale", 32'(validCycles), 32'd0);

    // Concurrency: push, INP and OUT in the same cycle
    host_in_valid = 1'b1; host_in_data = 8'h0F;
    applyStimulus(1);
    host_in_valid = 1'b0;
    applyStimulus(1);
    checkOutput("conc_pre_inpr", 32'(inpr), 32'h0F);
    host_in_valid = 1'b1; host_in_data = 8'h10;
    inp_ack = 1'b1;
    outr = 8'h20; out_strobe = 1'b1;
    applyStimulus(1);
    host_in_valid = 1'b0; inp_ack = 1'b0; out_strobe = 1'b0;
    checkOutput("conc_fgi_clr", 32'(fgi), 32'h0);
    checkOutput("conc_fgo_clr", 32'(fgo), 32'h0);
    applyStimulus(1);
    checkOutput("conc_fgi_set", 32'(fgi), 32'h1);
    checkOutput("conc_inpr",    32'(inpr), 32'h10);
    validCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (host_out_valid) begin
        validCycles = 1;
        break;
      end
      applyStimulus(1);
    end
    checkOutput("conc_out_seen", 32'(validCycles), 32'd1);
    checkOutput("conc_out_data", 32'(host_out_data), 32'h20);
    applyStimulus(1);
    checkOutput("conc_fgo_back", 32'(fgo), 32'h1);
    checkOutput("conc_no_ovr",   32'(out_overrun), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
